bcd_id_extract: RTL and testbench

- Sequential successor to the 4-digit ID decoder in the RFID reader path.
- Takes a received tag frame and extracts a parametrised binary ID field from it.
- Converts that field to packed BCD using a shift-add-3 algorithm that processes one bit per clock.
- Provides a start/busy/done handshake and an overflow flag. It feeds the 7-segment and UART display blocks downstream.

---
 rtl/bcd_id_extract.sv | 123 ++++++++++++
 tb/tb_bcd_id_extract.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_id_extract.sv
// Extracts a binary ID field from a received tag frame and converts it to packed BCD,
// one bit per clock, with saturation to all nines when the ID does not fit.
module bcd_id_extract #(
  parameter int FRAME_W = 45,
  parameter int ID_LSB  = 1,
  parameter int ID_W    = 16,
  parameter int DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [FRAME_W-1:0]    frame,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(ID_W) + 1;
  localparam int BCD_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ID_W - 1);

  typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic               sticky_q, sticky_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               overflow_q, overflow_d;

  logic [BCD_W-1:0]       adj;
  logic [BCD_W+ID_W:0]    shifted;
  logic                   unused_frame;

  // Only the ID field of the frame matters; the rest is deliberately ignored.
  assign unused_frame = ^frame;

  // Add-3 correction on every digit, evaluated in parallel before the shift.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5) ? scratch_q[4*gi +: 4] + 4'd3
                                                           : scratch_q[4*gi +: 4];
  end

  // Top bit is the carry out of the most significant digit.
  assign shifted = {adj, shift_q, 1'b0};

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    sticky_d   = sticky_q;
    count_d    = count_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = frame[ID_LSB + ID_W - 1 : ID_LSB];
          scratch_d = '0;
          sticky_d  = 1'b0;
          count_d   = '0;
          state_d   = CONV;
        end
      end
      CONV: begin
        scratch_d = shifted[BCD_W + ID_W - 1 : ID_W];
        shift_d   = shifted[ID_W - 1 : 0];
        sticky_d  = sticky_q | shifted[BCD_W + ID_W];
        count_d   = count_q + 1'b1;
        if (count_q == LAST_CNT) begin
          state_d = FIN;
        end
      end
      FIN: begin
        bcd_d      = sticky_q ? {DIGITS{4'h9}} : scratch_q;
        overflow_d = sticky_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      sticky_q   <= 1'b0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      sticky_q   <= sticky_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_id_extract.sv
// Bench for bcd_id_extract: per-cycle comparison against a decimal-arithmetic model,
// directed latency/boundary cases, and two parameter variants.
module tb_bcd_id_extract;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [44:0] frame0 = '0, frame1 = '0, frame2 = '0;

  logic        busy0, done0, ovf0;
  logic [15:0] bcd0;
  logic        busy1, done1, ovf1;
  logic [19:0] bcd1;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;

  int checks = 0;
  int failures = 0;

  bcd_id_extract u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .frame(frame0),
    .busy(busy0), .done(done0), .bcd(bcd0), .overflow(ovf0)
  );

  bcd_id_extract #(.DIGITS(5)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .frame(frame1),
    .busy(busy1), .done(done1), .bcd(bcd1), .overflow(ovf1)
  );

  bcd_id_extract #(.ID_W(8), .DIGITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .frame(frame2),
    .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2)
  );

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by division, saturating above 9999.
  function automatic logic [16:0] model_conv(input int unsigned id);
    logic [15:0] b;
    int unsigned d;
    if (id > 9999) return {1'b1, 16'h9999};
    b = '0;
    d = id;
    for (int i = 0; i < 4; i++) begin
      b[4*i +: 4] = 4'(d % 10);
      d = d / 10;
    end
    return {1'b0, b};
  endfunction

  // Cycle-level model of the default instance: a busy window of ID_W+1 cycles, then done.
  logic        m_busy, m_done, m_ovf;
  logic [15:0] m_bcd;
  logic [16:0] m_pend;
  int          m_rem;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_bcd  <= '0;
      m_ovf  <= 1'b0;
      m_pend <= '0;
      m_rem  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          {m_ovf, m_bcd} <= m_pend;
        end
      end else if (start0) begin
        m_pend <= model_conv(32'(frame0[16:1]));
        m_rem  <= 17;
        m_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_busy", 40'(busy0), 40'(m_busy));
    chk("cyc_done", 40'(done0), 40'(m_done));
    chk("cyc_bcd",  40'(bcd0),  40'(m_bcd));
    chk("cyc_ovf",  40'(ovf0),  40'(m_ovf));
    if (done0 === 1'b1) $display("txn bcd=%h overflow=%0d", bcd0, ovf0);
  end

  task automatic pulse0(input logic [15:0] id);
    frame0 = 45'({$urandom, $urandom});
    frame0[16:1] = id;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
  endtask

  task automatic wait_done0(output int n);
    n = 0;
    while (done0 !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic count_dones0(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done0 === 1'b1) pulses++;
    end
  endtask

  int n, pulses;
  logic [15:0] rid;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 40'(busy0), 40'd0);
    chk("rst_done", 40'(done0), 40'd0);
    chk("rst_bcd",  40'(bcd0),  40'd0);
    chk("rst_ovf",  40'(ovf0),  40'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    chk("model_4660",  40'(model_conv(4660)),  40'({1'b0, 16'h4660}));
    chk("model_9999",  40'(model_conv(9999)),  40'({1'b0, 16'h9999}));
    chk("model_10000", 40'(model_conv(10000)), 40'({1'b1, 16'h9999}));
    chk("model_42",    40'(model_conv(42)),    40'({1'b0, 16'h0042}));

    pulse0(16'd4660);
    chk("t1_busy_rise", 40'(busy0), 40'd1);
    wait_done0(n);
    chk("t1_latency", 40'(n), 40'd17);
    chk("t1_bcd", 40'(bcd0), 40'h4660);
    chk("t1_ovf", 40'(ovf0), 40'd0);

    pulse0(16'd0);
    wait_done0(n);
    chk("t2a_bcd", 40'(bcd0), 40'h0000);
    pulse0(16'd9999);
    wait_done0(n);
    chk("t2b_done_gap", 40'(n + 1), 40'd18);
    chk("t2b_bcd", 40'(bcd0), 40'h9999);
    chk("t2b_ovf", 40'(ovf0), 40'd0);

    pulse0(16'd10000);
    wait_done0(n);
    chk("t3a_bcd", 40'(bcd0), 40'h9999);
    chk("t3a_ovf", 40'(ovf0), 40'd1);
    pulse0(16'd65535);
    wait_done0(n);
    chk("t3b_bcd", 40'(bcd0), 40'h9999);
    chk("t3b_ovf", 40'(ovf0), 40'd1);
    pulse0(16'd42);
    wait_done0(n);
    chk("t3c_bcd", 40'(bcd0), 40'h0042);
    chk("t3c_ovf", 40'(ovf0), 40'd0);

    pulse0(16'd1234);
    repeat (4) begin @(posedge clk); #1; end
    frame0 = ~frame0;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    frame0 = 45'({$urandom, $urandom});
    wait_done0(n);
    chk("t4_latency", 40'(n), 40'd12);
    chk("t4_bcd", 40'(bcd0), 40'h1234);
    count_dones0(20, pulses);
    chk("t4_single_done", 40'(pulses), 40'd0);

    pulse0(16'd777);
    repeat (7) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_busy", 40'(busy0), 40'd0);
    chk("t5_async_bcd",  40'(bcd0),  40'd0);
    chk("t5_async_done", 40'(done0), 40'd0);
    chk("t5_async_ovf",  40'(ovf0),  40'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    count_dones0(30, pulses);
    chk("t5_no_done", 40'(pulses), 40'd0);
    pulse0(16'd42);
    wait_done0(n);
    chk("t5_restart_lat", 40'(n), 40'd17);
    chk("t5_restart_bcd", 40'(bcd0), 40'h0042);

    for (int c = 0; c < 1500; c++) begin
      case ($urandom_range(0, 3))
        0: rid = 16'($urandom_range(0, 65535));
        1: rid = 16'($urandom_range(9990, 10010));
        2: rid = 16'($urandom_range(0, 99));
        default: rid = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'h0000;
      endcase
      frame0 = 45'({$urandom, $urandom});
      frame0[16:1] = rid;
      start0 = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
    end
    start0 = 1'b0;
    repeat (25) begin @(posedge clk); #1; end

    frame1 = 45'({$urandom, $urandom});
    frame1[16:1] = 16'hFFFF;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 0;
    while (done1 !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
    chk("p1_latency", 40'(n), 40'd17);
    chk("p1_bcd", 40'(bcd1), 40'h65535);
    chk("p1_ovf", 40'(ovf1), 40'd0);

    frame2 = 45'({$urandom, $urandom});
    frame2[8:1] = 8'd200;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
    chk("p2a_latency", 40'(n), 40'd9);
    chk("p2a_bcd", 40'(bcd2), 40'h99);
    chk("p2a_ovf", 40'(ovf2), 40'd1);

    frame2 = 45'({$urandom, $urandom});
    frame2[8:1] = 8'd57;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
    chk("p2b_bcd", 40'(bcd2), 40'h57);
    chk("p2b_ovf", 40'(ovf2), 40'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
